// File: rtl/fifo_stream_reader.sv
// Read-side engine for the synchronous FIFO: drains LEN words on a start pulse and
// presents them on a valid/ready stream through a 2-entry skid buffer.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads and streaming words out
// FLUSH | abort seen, waiting for any in-flight read to return
// DONE  | one-cycle completion pulse
module fifo_stream_reader #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [LEN_W-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q, inflight_d;
    logic [WIDTH-1:0]   buf0_q, buf0_d;
    logic [WIDTH-1:0]   buf1_q, buf1_d;
    logic               aborted_q, aborted_d;

    logic               pop;
    logic               push;
    logic               has_room;
    logic               rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            xfer_cnt_q <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            xfer_cnt_q <= xfer_cnt_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            aborted_q  <= aborted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        xfer_cnt_d = xfer_cnt_q;
        occ_d      = occ_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        aborted_d  = aborted_q;

        pop  = (occ_q != 2'd0) && m_ready;
        // A returning word is dropped once abort is seen or we have left RUN.
        push = inflight_q && (state_q == S_RUN) && !abort;
        // Credit the word popped this cycle so a full-rate stream keeps reading.
        has_room = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        rd_en = (state_q == S_RUN) && !fifo_empty && (issued_q < len_q) && has_room && !abort;
        inflight_d = rd_en;

        if (rd_en) issued_d = issued_q + LEN_W'(1);
        if (pop)   xfer_cnt_d = xfer_cnt_q + LEN_W'(1);

        case (occ_q)
            2'd0: begin
                if (push) begin
                    buf0_d = fifo_data_out;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    buf0_d = fifo_data_out;
                end else if (push) begin
                    buf1_d = fifo_data_out;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    buf0_d = buf1_q;
                    if (push) buf1_d = fifo_data_out;
                    else      occ_d  = 2'd1;
                end
            end
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = len;
                    issued_d   = '0;
                    xfer_cnt_d = '0;
                    aborted_d  = 1'b0;
                    state_d    = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    occ_d   = 2'd0;
                    state_d = S_FLUSH;
                end else if (pop && ((xfer_cnt_q + LEN_W'(1)) == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_FLUSH: begin
                occ_d = 2'd0;
                if (!inflight_q) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fifo_rd_en = rd_en;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = buf0_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done       = (state_q == S_DONE);
    assign aborted    = (state_q == S_DONE) && aborted_q;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small FIFO model on the read side.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        fifo_empty;
    logic [15:0] fifo_data_out = 16'h0000;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  xfer_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_stream_reader #(.WIDTH(16), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
        .done(done), .aborted(aborted), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: storage written by the stimulus, read pointer owned by the clocked block
    logic [15:0] fmem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    logic        fifo_clr = 1'b0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= fmem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
        end
    end

    logic [15:0] got [$];
    int rd_count = 0;
    int rd_empty_err = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got.push_back(m_data);
            if (fifo_rd_en) rd_count = rd_count + 1;
            if (fifo_rd_en && fifo_empty) rd_empty_err = rd_empty_err + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic clear_fifo();
        cyc();
        fifo_clr = 1'b1;
        cyc();
        fifo_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] n);
        cyc();
        start = 1'b1;
        len   = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = 8'd0; abort = 1'b0; m_ready = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        n_assert++;
        if ({fifo_rd_en, m_valid, busy, done, aborted} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000", {fifo_rd_en, m_valid, busy, done, aborted});
        end
        n_assert++;
        if (xfer_cnt !== 8'd0 || m_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: xfer_cnt %0d m_data %h expected 0 0000", xfer_cnt, m_data);
        end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int base;
        base = got.size();
        for (int i = 0; i < 4; i++) push_word(16'(16'hA001 + i));
        m_ready = 1'b1;
        pulse_start(8'd4);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) cyc();
            @(negedge clk);
            n_assert++;
            if (fifo_rd_en !== (k <= 4)) begin
                n_fail++;
                $display("FAIL basic_rd_en cycle %0d: got %b expected %b", k, fifo_rd_en, (k <= 4));
            end
            n_assert++;
            if (m_valid !== (k >= 3 && k <= 6)) begin
                n_fail++;
                $display("FAIL basic_valid cycle %0d: got %b expected %b", k, m_valid, (k >= 3 && k <= 6));
            end
            if (k >= 3 && k <= 6) begin
                n_assert++;
                if (m_data !== 16'(16'hA000 + k - 2)) begin
                    n_fail++;
                    $display("FAIL basic_data cycle %0d: got %h expected %h", k, m_data, 16'(16'hA000 + k - 2));
                end
            end
            n_assert++;
            if (done !== (k == 7) || busy !== (k <= 6)) begin
                n_fail++;
                $display("FAIL basic_done_busy cycle %0d: got done %b busy %b", k, done, busy);
            end
            if (k == 7) begin
                n_assert++;
                if (xfer_cnt !== 8'd4 || aborted !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_end: xfer_cnt %0d aborted %b expected 4 0", xfer_cnt, aborted);
                end
            end
        end
        n_assert++;
        if (got.size() - base !== 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d words expected 4", got.size() - base);
        end
    endtask

    task automatic test_backpressure();
        int base, rd0;
        logic pv, pr, seen;
        logic [15:0] pd;
        base = got.size(); rd0 = rd_count;
        pv = 1'b0; pr = 1'b0; pd = 16'h0; seen = 1'b0;
        for (int i = 0; i < 6; i++) push_word(16'(16'hB001 + i));
        m_ready = 1'b1;
        pulse_start(8'd6);
        for (int k = 1; k <= 30 && !seen; k++) begin
            if (k > 1) cyc();
            m_ready = !(k >= 3 && k <= 5);
            @(negedge clk);
            if (k >= 3 && k <= 5) begin
                n_assert++;
                if (fifo_rd_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_rd_stall cycle %0d: got %b expected 0", k, fifo_rd_en);
                end
            end
            if (pv && !pr) begin
                n_assert++;
                if (m_valid !== 1'b1 || m_data !== pd) begin
                    n_fail++;
                    $display("FAIL bp_hold cycle %0d: got valid %b data %h expected 1 %h", k, m_valid, m_data, pd);
                end
            end
            pv = m_valid; pr = m_ready; pd = m_data;
            if (done) begin
                seen = 1'b1;
                n_assert++;
                if (xfer_cnt !== 8'd6) begin
                    n_fail++;
                    $display("FAIL bp_xfer_cnt: got %0d expected 6", xfer_cnt);
                end
            end
        end
        n_assert++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_timeout: got no done expected done");
        end
        n_assert++;
        if (got.size() - base !== 6 || rd_count - rd0 !== 6) begin
            n_fail++;
            $display("FAIL bp_counts: got %0d words %0d reads expected 6 6", got.size() - base, rd_count - rd0);
        end
        for (int i = 0; i < 6; i++) begin
            if (base + i < got.size()) begin
                n_assert++;
                if (got[base + i] !== 16'(16'hB001 + i)) begin
                    n_fail++;
                    $display("FAIL bp_order word %0d: got %h expected %h", i, got[base + i], 16'(16'hB001 + i));
                end
            end
        end
    endtask

    task automatic test_empty_gap();
        int base, rd0, err0;
        logic seen;
        base = got.size(); rd0 = rd_count; err0 = rd_empty_err; seen = 1'b0;
        push_word(16'hC001);
        m_ready = 1'b1;
        pulse_start(8'd3);
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (k > 1) cyc();
            if (k == 7) begin
                push_word(16'hC002);
                push_word(16'hC003);
            end
            @(negedge clk);
            if (k == 4) begin
                n_assert++;
                if (fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL empty_wait: got rd_en %b busy %b expected 0 1", fifo_rd_en, busy);
                end
            end
            if (done) begin
                seen = 1'b1;
                n_assert++;
                if (xfer_cnt !== 8'd3) begin
                    n_fail++;
                    $display("FAIL empty_xfer_cnt: got %0d expected 3", xfer_cnt);
                end
            end
        end
        n_assert++;
        if (!seen || rd_count - rd0 !== 3 || rd_empty_err !== err0) begin
            n_fail++;
            $display("FAIL empty_reads: done %b reads %0d empty_reads %0d expected 1 3 0", seen, rd_count - rd0, rd_empty_err - err0);
        end
        n_assert++;
        if (got.size() - base !== 3) begin
            n_fail++;
            $display("FAIL empty_count: got %0d words expected 3", got.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (got[base + i] !== 16'(16'hC001 + i)) begin
                    n_fail++;
                    $display("FAIL empty_order word %0d: got %h expected %h", i, got[base + i], 16'(16'hC001 + i));
                end
            end
        end
    endtask

    task automatic test_len_zero();
        int n_done, n_rd, n_busy;
        n_done = 0; n_rd = 0; n_busy = 0;
        push_word(16'hEEEE);
        pulse_start(8'd0);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) cyc();
            @(negedge clk);
            if (done) begin
                n_done++;
                n_assert++;
                if (xfer_cnt !== 8'd0 || aborted !== 1'b0) begin
                    n_fail++;
                    $display("FAIL len0_end: xfer_cnt %0d aborted %b expected 0 0", xfer_cnt, aborted);
                end
            end
            if (fifo_rd_en) n_rd++;
            if (busy) n_busy++;
        end
        n_assert++;
        if (n_done !== 1 || n_rd !== 0 || n_busy !== 0) begin
            n_fail++;
            $display("FAIL len0_pulse: done %0d rd %0d busy %0d expected 1 0 0", n_done, n_rd, n_busy);
        end
        clear_fifo();
    endtask

    task automatic test_abort();
        int base, acc, phase;
        logic seen;
        base = got.size(); acc = 0; phase = 0; seen = 1'b0;
        for (int i = 0; i < 8; i++) push_word(16'(16'hD001 + i));
        m_ready = 1'b1;
        pulse_start(8'd8);
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (k > 1) cyc();
            if (phase == 1) begin
                abort = 1'b1; m_ready = 1'b0; start = 1'b1; len = 8'd2;
            end else if (phase == 2) begin
                abort = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            if (phase == 0) begin
                if (m_valid && m_ready) acc++;
                if (acc == 3) phase = 1;
            end else if (phase == 1) begin
                n_assert++;
                if (fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_rd_en: got rd_en %b busy %b expected 0 1", fifo_rd_en, busy);
                end
                phase = 2;
            end else if (phase == 2) begin
                n_assert++;
                if (m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_flush: got m_valid %b expected 0", m_valid);
                end
                phase = 3;
            end else if (done) begin
                seen = 1'b1;
                n_assert++;
                if (aborted !== 1'b1 || xfer_cnt !== 8'd3) begin
                    n_fail++;
                    $display("FAIL abort_end: aborted %b xfer_cnt %0d expected 1 3", aborted, xfer_cnt);
                end
            end
        end
        n_assert++;
        if (!seen) begin
            n_fail++;
            $display("FAIL abort_timeout: got no done expected done");
        end
        cyc();
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_start_ignored: busy %b done %b expected 0 0", busy, done);
        end
        n_assert++;
        if (got.size() - base !== 3) begin
            n_fail++;
            $display("FAIL abort_count: got %0d words expected 3", got.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (got[base + i] !== 16'(16'hD001 + i)) begin
                    n_fail++;
                    $display("FAIL abort_order word %0d: got %h expected %h", i, got[base + i], 16'(16'hD001 + i));
                end
            end
        end
        clear_fifo();
    endtask

    task automatic test_reset_mid();
        int base;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'(16'hE001 + i));
        m_ready = 1'b0;
        pulse_start(8'd4);
        cyc(); cyc(); cyc();
        @(negedge clk);
        n_assert++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: m_valid %b busy %b expected 1 1", m_valid, busy);
        end
        cyc();
        rst = 1'b1;
        cyc();
        n_assert++;
        if ({fifo_rd_en, m_valid, busy, done, aborted} !== 5'b0 || xfer_cnt !== 8'd0 || m_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: flags %b xfer_cnt %0d m_data %h expected 00000 0 0000",
                     {fifo_rd_en, m_valid, busy, done, aborted}, xfer_cnt, m_data);
        end
        rst = 1'b0;
        clear_fifo();
        base = got.size();
        push_word(16'hF001);
        push_word(16'hF002);
        m_ready = 1'b1;
        pulse_start(8'd2);
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (k > 1) cyc();
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                n_assert++;
                if (xfer_cnt !== 8'd2 || aborted !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_restart_end: xfer_cnt %0d aborted %b expected 2 0", xfer_cnt, aborted);
                end
            end
        end
        n_assert++;
        if (!seen || got.size() - base !== 2) begin
            n_fail++;
            $display("FAIL rstmid_restart: done %b words %0d expected 1 2", seen, got.size() - base);
        end else begin
            n_assert++;
            if (got[base] !== 16'hF001 || got[base + 1] !== 16'hF002) begin
                n_fail++;
                $display("FAIL rstmid_order: got %h %h expected F001 F002", got[base], got[base + 1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_gap();
        test_len_zero();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
